// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage between the 64-word instruction memory and decode.
// It owns the program counter and drives the memory address combinationally.
// The memory returns registered read data one cycle later. This block pairs
// that data with the address it came from and with a valid flag. Decode
// back-pressure uses a valid/ready handshake. Execute-stage redirects replace
// the instruction currently offered to decode, so wrong-path fetches are
// squashed without inserting bubbles.
//
// Parameters:
//   ADDR_W   instruction word-address width (PC counts words)
//   DATA_W   instruction width
//   RESET_PC PC loaded on reset
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   imem_addr     address to instruction memory (combinational)
//   imem_data     registered read data from instruction memory
//   redirect      execute requests a PC change this cycle
//   redirect_pc   redirect target word address
//   id_valid      id_inst/id_pc hold a valid instruction
//   id_ready      decode accepts this cycle
//   id_inst       instruction to decode (passes imem_data straight through)
//   id_pc         address of id_inst
//   perf_fetched  accepted-instruction count
//   perf_stalls   back-pressure cycle count
//
// Build option:
//   FETCH_PERF_CNT_EN  when defined, builds saturating 16-bit performance
//                      counters. When undefined, perf_fetched and perf_stalls
//                      are tied to zero.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stalls
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] cur_pc_q;
  logic              valid_q;
  logic              stall;

  // A redirect always wins over back-pressure. The instruction on the decode
  // port is discarded whether or not decode is ready.
  assign stall = valid_q && !id_ready && !redirect;

  assign id_pc    = cur_pc_q;
  assign id_valid = valid_q;
  assign id_inst  = imem_data;

  // Address selection. A stall re-reads the address being presented so the
  // registered memory output keeps showing the same word. Without the
  // re-read, imem_data would advance under a held id_pc.
  always_comb begin
    imem_addr = pc_q;
    if (redirect) begin
      imem_addr = redirect_pc;
    end else if (stall) begin
      imem_addr = cur_pc_q;
    end
  end

  // PC pipeline. cur_pc_q tracks the address the memory is returning this
  // cycle. pc_q is the next address to request. Increments wrap modulo
  // 2^ADDR_W through natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      cur_pc_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else if (redirect) begin
      cur_pc_q <= redirect_pc;
      pc_q     <= redirect_pc + PC_ONE;
      valid_q  <= 1'b1;
    end else if (!stall) begin
      cur_pc_q <= pc_q;
      pc_q     <= pc_q + PC_ONE;
      valid_q  <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        transfer;
  logic [15:0] fetched_q;
  logic [15:0] stalls_q;

  // A transfer is a handshake that a simultaneous redirect does not cancel.
  assign transfer = valid_q && id_ready && !redirect;

  // Saturating event counters. Each counter holds at all-ones instead of
  // wrapping, so a long run never reads as a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (transfer && (fetched_q != 16'hFFFF)) begin
        fetched_q <= fetched_q + 16'd1;
      end
      if (stall && (stalls_q != 16'hFFFF)) begin
        stalls_q <= stalls_q + 16'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the 64-word instruction memory and directly downstream feeds the decode stage. Owns the program counter and drives the memory address. Pairs the memory's registered (1-cycle) read data with its PC and a valid flag. Handles decode back-pressure via a valid/ready handshake and execute-stage redirects (branch/jump), including squash of wrong-path fetches.

## Interface
- ADDR_W, 6, instruction word-address width; PC counts words
- DATA_W, 32, instruction width
- RESET_PC, 0, PC loaded on reset
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  ADDR_W  address to instruction memory; combinational
- imem_data  in  DATA_W  instruction memory read data, registered in memory: the value equals mem[imem_addr sampled at previous edge]
- redirect  in  1  execute requests PC change this cycle
- redirect_pc  in  ADDR_W  target word address
- id_valid  out  1  id_inst/id_pc hold a valid instruction
- id_ready  in  1  decode accepts this cycle
- id_inst  out  DATA_W  instruction; equals imem_data
- id_pc  out  ADDR_W  address of id_inst
- perf_fetched  out  16  accepted-instruction count (see Configuration)
- perf_stalls  out  16  back-pressure cycle count (see Configuration)

## Operation
- Registers: pc_q (next address to fetch), cur_pc_q (address whose data is on imem_data), valid_q.
- id_pc = cur_pc_q; id_valid = valid_q; id_inst = imem_data (no extra register).
- stall = valid_q && !id_ready && !redirect.
- imem_addr priority: redirect -> redirect_pc; else stall -> cur_pc_q (re-read, keeps imem_data stable); else pc_q.
- Edge update:
  - redirect: cur_pc_q <= redirect_pc; pc_q <= redirect_pc+1; valid_q <= 1. Current id instruction is squashed (replaced, never accepted even if id_ready=1 this cycle — decode ignores handshake when redirect is high).
  - stall: all registers hold.
  - otherwise: cur_pc_q <= pc_q; pc_q <= pc_q+1; valid_q <= 1.
- Arithmetic: PC increment modulo 2^ADDR_W; 63 wraps to 0, redirect_pc=63 gives pc_q=0.
- Redirect beats stall; redirect while id_valid=0 behaves identically.
- Transfer occurs on id_valid && id_ready && !redirect.

## Timing
- Reset (async, immediate): pc_q=RESET_PC, cur_pc_q=RESET_PC, valid_q=0, perf counters=0; imem_addr=RESET_PC while rst high.
- First edge after rst deasserts: memory captures mem[RESET_PC]; id_valid=1, id_pc=RESET_PC next cycle.
- Steady-state throughput: one instruction/cycle with id_ready held high.
- Redirect latency: target instruction presented with id_valid=1 the cycle after redirect; zero bubbles.
- Stall: id_inst/id_pc stable for every stalled cycle; resumes with next sequential PC the cycle after id_ready rises.
- Reset mid-stall or mid-redirect: abandons everything; restarts as above.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_fetched increments on each transfer; perf_stalls increments on each stall cycle; both 16-bit, saturate at 0xFFFF, cleared by rst.
- Not defined: counters not built; perf_fetched and perf_stalls tied to 0.

## Test plan
- Reset release, id_ready=1, memory preloaded word i = i: id_pc sequence 0,1,2,… one per cycle, id_inst matches, id_valid low only in the first cycle.
- id_ready=0 for 3 cycles while id_pc=5: id_pc=5 and id_inst=mem[5] stable 3 cycles; imem_addr=5 during stall; next accepted id_pc=6; perf_stalls=3 (if enabled).
- redirect=1, redirect_pc=20 while id_pc=7 and id_ready=0: next cycle id_pc=20, id_valid=1; instruction 7 never counted in perf_fetched.
- Run from 62 with id_ready=1: id_pc 62,63,0,1; redirect_pc=63 -> id_pc 63 then 0.
- Assert rst for half a cycle mid-run at id_pc=30: id_valid drops immediately, imem_addr=0; after release sequence restarts at 0.
- With FETCH_PERF_CNT_EN, force 70000 transfers: perf_fetched holds 0xFFFF; without macro both perf outputs read 0 throughout.
